// File: rtl/fwd_interlock_unit.sv
// Forwarding select and load-use interlock for the ID->EX boundary.
// A shift table follows every in-flight register producer from EX to the last forwarding stage.
module fwd_interlock_unit #(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 2,
   parameter int REG_BITS = 5,
   parameter int SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        id_valid,
   input  logic [NUM_SRC*REG_BITS-1:0] id_src,
   input  logic [NUM_SRC-1:0]          id_src_used,
   input  logic [REG_BITS-1:0]         id_rd,
   input  logic                        id_regwrite,
   input  logic [SEL_W-1:0]            id_lat,
   input  logic                        kill_ex,
   output logic                        stall,
   output logic [NUM_SRC*SEL_W-1:0]    fwd_sel
);

   logic [DEPTH-1:0]    e_v;
   logic [REG_BITS-1:0] e_rd  [DEPTH];
   logic [SEL_W-1:0]    e_lat [DEPTH];

   logic [NUM_SRC*SEL_W-1:0] next_sel;
   logic [NUM_SRC-1:0]       blocked;
   logic                     ins_v;

   always_comb begin
      next_sel = '0;
      blocked  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         // Walk from the oldest entry to the youngest so the youngest match has the last word.
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_valid && id_src_used[i] && e_v[k] &&
                (e_rd[k] == id_src[i*REG_BITS +: REG_BITS]) &&
                (id_src[i*REG_BITS +: REG_BITS] != '0)) begin
               if (SEL_W'(k + 1) >= e_lat[k]) begin
                  next_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                  blocked[i]                 = 1'b0;
               end else begin
                  next_sel[i*SEL_W +: SEL_W] = '0;
                  blocked[i]                 = 1'b1;
               end
            end
         end
      end
   end

   assign stall = |blocked;
   // A stalled ID instruction does not enter EX, so it is not a producer yet.
   assign ins_v = id_valid & id_regwrite & (id_rd != '0) & ~stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         e_v     <= '0;
         fwd_sel <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            e_rd[k]  <= '0;
            e_lat[k] <= '0;
         end
      end else begin
         e_v[0]   <= ins_v;
         e_rd[0]  <= id_rd;
         e_lat[0] <= id_lat;
         for (int k = 1; k < DEPTH; k++) begin
            e_v[k]   <= (k == 1) ? (e_v[0] & ~kill_ex) : e_v[k-1];
            e_rd[k]  <= e_rd[k-1];
            e_lat[k] <= e_lat[k-1];
         end
         fwd_sel <= (stall || !id_valid) ? '0 : next_sel;
      end
   end

endmodule
